alu_rr_scheduler: RTL and testbench
===================================

# alu_rr_scheduler

Two-requester round-robin scheduler that shares one `alu_simple` datapath. Each requester presents an operation with a valid/ready handshake. The scheduler grants one requester, registers its operands and control onto the ALU inputs, waits a fixed settle time, captures the result, and returns it on a single tagged response channel. It sits between the instruction-issue stages and the ALU; no operand path reaches the ALU except through this block.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width.
- `ALU_LAT`, 1, cycles the ALU inputs are held before the result is sampled. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid` / `req1_valid`  in  1  requester N presents an operation.
- `req0_ready` / `req1_ready`  out  1  requester N's operation is accepted this cycle.
- `req0_in1` / `req1_in1`  in  WIDTH  operand A.
- `req0_in2` / `req1_in2`  in  WIDTH  operand B (pre-shift source).
- `req0_ctl` / `req1_ctl`  in  12  {opcode[11:8], sr_cont[7:5], sr_bit[4:0]}.
- `alu_in1`, `alu_in2`  out  WIDTH  registered ALU operands.
- `alu_opcode`  out  4  registered ALU opcode.
- `alu_sr_cont`  out  3  registered ALU shift control.
- `alu_sr_bit`  out  5  registered ALU shift amount.
- `alu_out`  in  WIDTH  ALU result.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  1  requester that issued the operation.
- `rsp_data`  out  WIDTH  result.
- `rsp_err`  out  1  opcode was illegal; `rsp_data` is 0.

## Operation
States: IDLE, EXEC, RESP.

IDLE:
- Arbitrate among the valid requesters using round-robin pointer `prio`.
- If both are valid, grant `prio`. If only one is valid, grant that one.
- `reqN_ready` = (state==IDLE) && granted N. This is combinational from `reqN_valid` and `prio`. At most one ready is high.
- On the accept edge:
  - register in1/in2/ctl onto the `alu_*` outputs;
  - latch `rsp_id`;
  - set `prio` to the non-granted requester.
- Legal opcode (0000–0101): go to EXEC with counter = ALU_LAT-1.
- Illegal opcode (0110–1111): skip EXEC. Go directly to RESP with `rsp_err`=1 and `rsp_data`=0. The `alu_*` outputs are still updated.

EXEC:
- Counter decrements each cycle.
- When counter is 0: `rsp_data` <= `alu_out`, `rsp_err` <= 0, go to RESP.
- `alu_*` outputs stay stable for the whole of EXEC.

RESP:
- `rsp_valid`=1.
- `rsp_id`, `rsp_data` and `rsp_err` are held stable until `rsp_valid && rsp_ready`.
- On that handshake edge: go to IDLE, `rsp_valid` <= 0.

Other rules:
- `sr_cont` values 100–111 are forwarded unchanged; the ALU treats them as no shift.
- Requesters may drop `valid` before `ready`. No acceptance occurs without `ready`.
- The `alu_*` outputs retain their last value outside EXEC. No gating to zero is applied.

## Timing
- Reset (async assert, release synchronous to `clk`) gives:
  - state IDLE, `prio`=0;
  - `alu_in1`/`alu_in2`=0, `alu_opcode`=0, `alu_sr_cont`=0, `alu_sr_bit`=0;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0;
  - both `req_ready`=0 while `rst_n`=0.
- Accept at edge T. `rsp_valid` rises after edge T+ALU_LAT. With ALU_LAT=1, the response is visible the cycle after acceptance.
- Illegal opcode: `rsp_valid` rises after edge T (no EXEC cycles).
- Handshake at edge R. The next accept is at edge R+1 at the earliest. Steady-state throughput is one operation per ALU_LAT+2 cycles with `rsp_ready` held high.
- Reset mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is produced, and all registers return to reset values immediately.
- `rsp_ready` high in IDLE or EXEC has no effect.

## Test plan
- Single op, req0: in1=5, in2=3, ctl opcode 0000, sr_cont 000. Result: `rsp_valid` after 1 cycle with data=8, id=0, err=0; `req0_ready` high exactly 1 cycle.
- Both valid continuously, ALU_LAT=1, `rsp_ready`=1. Ops: req0 opcode 0001 (10-4), req1 opcode 0010 (6*7). Grants alternate 0,1,0,1. Responses: 6(id0), 42(id1), repeating. The cadence is one op per 3 cycles.
- Shift path: req1 in1=1, in2=0x0000_0010, opcode 0000, sr_cont 001, sr_bit 4. Result: data=2 (in2>>4 = 1, plus in1 = 1), id=1.
- Illegal opcode 1010 from req0. Result: `rsp_valid` on the cycle after accept with err=1, data=0. The next accepted op proceeds normally.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP. Result: data/id/err are stable, both `req_ready`=0, and `req1_valid` waits. After release, req1 is accepted one cycle after the handshake.
- Reset: deassert `rst_n` one cycle into EXEC with ALU_LAT=3. Result: `rsp_valid` never rises for that op, and all outputs are 0. After release, req0 wins when both are valid.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: two-requester round-robin front end for a shared ALU with a tagged response channel
module alu_rr_scheduler #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_in1,
  input  logic [WIDTH-1:0] req0_in2,
  input  logic [11:0]      req0_ctl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_in1,
  input  logic [WIDTH-1:0] req1_in2,
  input  logic [11:0]      req1_ctl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_opcode,
  output logic [2:0]       alu_sr_cont,
  output logic [4:0]       alu_sr_bit,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  // counter reload so the result is sampled ALU_LAT edges after the operands are registered
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [11:0]      alu_ctl_q, alu_ctl_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             gnt0, gnt1, acc, legal;
  logic [WIDTH-1:0] sel_in1, sel_in2;
  logic [11:0]      sel_ctl;

  // arbitration: prio breaks ties, a lone requester always wins; ready is masked while in reset
  always_comb begin
    gnt0       = req0_valid && (!req1_valid || !prio_q);
    gnt1       = req1_valid && (!req0_valid || prio_q);
    req0_ready = rst_n && (state_q == IDLE) && gnt0;
    req1_ready = rst_n && (state_q == IDLE) && gnt1;
    acc        = req0_ready || req1_ready;
    sel_in1    = req1_ready ? req1_in1 : req0_in1;
    sel_in2    = req1_ready ? req1_in2 : req0_in2;
    sel_ctl    = req1_ready ? req1_ctl : req0_ctl;
    legal      = sel_ctl[11:8] <= 4'd5;
  end

  // state register and all datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      alu_ctl_q  <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
      alu_ctl_q  <= alu_ctl_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // next state: illegal opcodes bypass EXEC and respond immediately
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && acc)
      state_d = legal ? EXEC : RESP;
    else if (state_q == EXEC && cnt_q == 4'd0)
      state_d = RESP;
    else if (state_q == RESP && rsp_ready)
      state_d = IDLE;
  end

  // datapath: capture operands on accept, count down the settle time, sample the ALU result
  always_comb begin
    prio_d     = prio_q;
    cnt_d      = (state_q == EXEC && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    alu_ctl_d  = alu_ctl_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (state_q == IDLE && acc) begin
      prio_d     = !req1_ready;
      cnt_d      = LAT_M1;
      alu_in1_d  = sel_in1;
      alu_in2_d  = sel_in2;
      alu_ctl_d  = sel_ctl;
      rsp_id_d   = req1_ready;
      rsp_data_d = '0;
      rsp_err_d  = !legal;
    end else if (state_q == EXEC && cnt_q == 4'd0) begin
      rsp_data_d = alu_out;
      rsp_err_d  = 1'b0;
    end
  end

  // outputs straight from registers; the ALU inputs are never gated
  always_comb begin
    alu_in1     = alu_in1_q;
    alu_in2     = alu_in2_q;
    alu_opcode  = alu_ctl_q[11:8];
    alu_sr_cont = alu_ctl_q[7:5];
    alu_sr_bit  = alu_ctl_q[4:0];
    rsp_valid   = state_q == RESP;
    rsp_id      = rsp_id_q;
    rsp_data    = rsp_data_q;
    rsp_err     = rsp_err_q;
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed checks of arbitration, latency, illegal opcodes, backpressure and reset
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference ALU: optional pre-shift of in2, then the arithmetic/logic op
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op, input logic [2:0] sc, input logic [4:0] sb);
    logic [31:0] s;
    s = sc == 3'b001 ? b >> sb : sc == 3'b010 ? b << sb : sc == 3'b011 ? 32'($signed(b) >>> sb) : b;
    return op == 4'd0 ? a + s : op == 4'd1 ? a - s : op == 4'd2 ? a * s :
           op == 4'd3 ? a & s : op == 4'd4 ? a | s : op == 4'd5 ? a ^ s : 32'd0;
  endfunction

  logic        rst_n, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [11:0] req0_ctl, req1_ctl;
  logic [31:0] alu_in1, alu_in2, alu_out, rsp_data;
  logic [3:0]  alu_opcode;
  logic [2:0]  alu_sr_cont;
  logic [4:0]  alu_sr_bit;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;

  assign alu_out = alu_f(alu_in1, alu_in2, alu_opcode, alu_sr_cont, alu_sr_bit);

  alu_rr_scheduler #(.WIDTH(32), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctl(req1_ctl),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_sr_cont(alu_sr_cont), .alu_sr_bit(alu_sr_bit),
    .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  logic        b_rst_n, b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [31:0] b_req0_in1, b_req0_in2, b_req1_in1, b_req1_in2;
  logic [11:0] b_req0_ctl, b_req1_ctl;
  logic [31:0] b_alu_in1, b_alu_in2, b_alu_out, b_rsp_data;
  logic [3:0]  b_alu_opcode;
  logic [2:0]  b_alu_sr_cont;
  logic [4:0]  b_alu_sr_bit;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_err;

  assign b_alu_out = alu_f(b_alu_in1, b_alu_in2, b_alu_opcode, b_alu_sr_cont, b_alu_sr_bit);

  alu_rr_scheduler #(.WIDTH(32), .ALU_LAT(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_in1(b_req0_in1), .req0_in2(b_req0_in2), .req0_ctl(b_req0_ctl),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_in1(b_req1_in1), .req1_in2(b_req1_in2), .req1_ctl(b_req1_ctl),
    .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_opcode(b_alu_opcode), .alu_sr_cont(b_alu_sr_cont), .alu_sr_bit(b_alu_sr_bit),
    .alu_out(b_alu_out), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
  );

  task automatic test_reset;
    rst_n = 1'b0; b_rst_n = 1'b0; rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    req0_in1 = '0; req0_in2 = '0; req0_ctl = '0; req1_in1 = '0; req1_in2 = '0; req1_ctl = '0;
    b_req0_in1 = '0; b_req0_in2 = '0; b_req0_ctl = '0; b_req1_in1 = '0; b_req1_in2 = '0; b_req1_ctl = '0;
    #3;
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== 35'd0) begin n_fail++; $display("FAIL reset_rsp got v%b id%b e%b d%h want all 0", rsp_valid, rsp_id, rsp_err, rsp_data); end
    n_chk++;
    if ({alu_in1, alu_in2, alu_opcode, alu_sr_cont, alu_sr_bit} !== 76'd0) begin n_fail++; $display("FAIL reset_alu got %h %h %h %h %h want all 0", alu_in1, alu_in2, alu_opcode, alu_sr_cont, alu_sr_bit); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    req0_in1 = 32'd5; req0_in2 = 32'd3; req0_ctl = 12'h000; req0_valid = 1'b1;
    #1;
    n_chk++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if ({req0_ready, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL single_exec got ready%b v%b want 00", req0_ready, rsp_valid); end
    n_chk++;
    if ({alu_in1, alu_in2} !== {32'd5, 32'd3}) begin n_fail++; $display("FAIL single_alu got %0d %0d want 5 3", alu_in1, alu_in2); end
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b100, 32'd8}) begin n_fail++; $display("FAIL single_rsp got v%b id%b e%b d%0d want v1 id0 e0 d8", rsp_valid, rsp_id, rsp_err, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_done got v%b want 0", rsp_valid); end
  endtask

  task automatic test_shift;
    req1_in1 = 32'd1; req1_in2 = 32'h0000_0010; req1_ctl = {4'b0000, 3'b001, 5'd4}; req1_valid = 1'b1;
    #1;
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL shift_ready got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    n_chk++;
    if ({alu_sr_cont, alu_sr_bit} !== {3'b001, 5'd4}) begin n_fail++; $display("FAIL shift_ctl got %b %0d want 001 4", alu_sr_cont, alu_sr_bit); end
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b110, 32'd2}) begin n_fail++; $display("FAIL shift_rsp got v%b id%b e%b d%0d want v1 id1 e0 d2", rsp_valid, rsp_id, rsp_err, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_alternate;
    req0_in1 = 32'd10; req0_in2 = 32'd4; req0_ctl = {4'b0001, 8'd0};
    req1_in1 = 32'd6;  req1_in2 = 32'd7; req1_ctl = {4'b0010, 8'd0};
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_grant%0d got %b", k, {req0_ready, req1_ready}); end
      @(negedge clk);
      n_chk++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin n_fail++; $display("FAIL alt_exec%0d got %b want 000", k, {rsp_valid, req0_ready, req1_ready}); end
      @(negedge clk);
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== ((k % 2 == 0) ? {3'b100, 32'd6} : {3'b110, 32'd42})) begin n_fail++; $display("FAIL alt_rsp%0d got v%b id%b e%b d%0d", k, rsp_valid, rsp_id, rsp_err, rsp_data); end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_illegal;
    req0_in1 = 32'd9; req0_in2 = 32'd9; req0_ctl = {4'b1010, 8'd0}; req0_valid = 1'b1;
    #1;
    n_chk++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b101, 32'd0}) begin n_fail++; $display("FAIL ill_rsp got v%b id%b e%b d%0d want v1 id0 e1 d0", rsp_valid, rsp_id, rsp_err, rsp_data); end
    n_chk++;
    if ({alu_opcode, alu_in1} !== {4'b1010, 32'd9}) begin n_fail++; $display("FAIL ill_alu got op%b in1 %0d want 1010 9", alu_opcode, alu_in1); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_in1 = 32'd2; req0_in2 = 32'd3; req0_ctl = 12'h000; req0_valid = 1'b1;
    #1;
    n_chk++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL ill_next_ready got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ill_next_exec got v%b want 0", rsp_valid); end
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'd5}) begin n_fail++; $display("FAIL ill_next_rsp got v%b e%b d%0d want v1 e0 d5", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    req0_in1 = 32'd100; req0_in2 = 32'd1; req0_ctl = {4'b0001, 8'd0}; req0_valid = 1'b1;
    #1;
    n_chk++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_in1 = 32'd7; req1_in2 = 32'd8; req1_ctl = 12'h000; req1_valid = 1'b1;
    #1;
    n_chk++;
    if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_exec_ready got %b want 0", req1_ready); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, rsp_data} !== {5'b10000, 32'd99}) begin n_fail++; $display("FAIL bp_hold%0d got v%b id%b e%b r%b%b d%0d want v1 id0 e0 r00 d99", k, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, rsp_data); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_chk++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release got v%b r1%b want v0 r1", rsp_valid, req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b110, 32'd15}) begin n_fail++; $display("FAIL bp_next_rsp got v%b id%b e%b d%0d want v1 id1 e0 d15", rsp_valid, rsp_id, rsp_err, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec;
    b_req1_in1 = 32'd3; b_req1_in2 = 32'd4; b_req1_ctl = 12'h000; b_req1_valid = 1'b1;
    #1;
    n_chk++;
    if (b_req1_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", b_req1_ready); end
    @(negedge clk);
    b_req1_valid = 1'b0;
    b_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({b_rsp_valid, b_rsp_id, b_rsp_err, b_rsp_data, b_alu_in1, b_alu_in2} !== 99'd0) begin n_fail++; $display("FAIL rst_mid_clear got v%b id%b d%0d in1 %0d in2 %0d want 0", b_rsp_valid, b_rsp_id, b_rsp_data, b_alu_in1, b_alu_in2); end
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet%0d got v%b want 0", k, b_rsp_valid); end
    end
    b_req0_in1 = 32'd20; b_req0_in2 = 32'd5; b_req0_ctl = 12'h000;
    b_req0_valid = 1'b1; b_req1_valid = 1'b1;
    #1;
    n_chk++;
    if ({b_req0_ready, b_req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_prio got %b want 10", {b_req0_ready, b_req1_ready}); end
    @(negedge clk);
    b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++;
      if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat3_wait%0d got v%b want 0", k, b_rsp_valid); end
    end
    @(negedge clk);
    n_chk++;
    if ({b_rsp_valid, b_rsp_id, b_rsp_err, b_rsp_data} !== {3'b100, 32'd25}) begin n_fail++; $display("FAIL lat3_rsp got v%b id%b e%b d%0d want v1 id0 e0 d25", b_rsp_valid, b_rsp_id, b_rsp_err, b_rsp_data); end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_shift;
    test_alternate;
    test_illegal;
    test_backpressure;
    test_reset_mid_exec;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
